// File: rtl/apb_req_pkg.sv
// Shared types for the APB request master: FSM states, queued request record and bus widths.
package apb_req_pkg;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } req_t;

    localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/apb_req_fifo.sv
// Generic synchronous FIFO with registered ready (not-full) and empty flags.
// Latency: an entry pushed at edge N is presented at the head (out_vld) from edge N.
// Backpressure: in_rdy is registered and is low whenever the next edge would leave the FIFO full.
module apb_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apb_req_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;
    logic             empty_q, empty_d;
    logic             push, pop;

    assign push    = in_vld & rdy_q;
    assign pop     = out_rdy & ~empty_q;
    assign in_rdy  = rdy_q;
    assign out_vld = ~empty_q;
    assign out_dat = mem_q[rd_ptr_q];

    // Flags come from the next count so that they are exact registered values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        rdy_d   = (cnt_d != CNT_W'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_dat;
        end
    end

endmodule

// File: rtl/apb_req_master.sv
// APB master draining a request FIFO; optional ACCESS timeout under APB_REQ_MASTER_TIMEOUT_EN.
// Latency: request accepted at edge N into an idle master gives SETUP N+1, ACCESS N+2, rsp_valid N+3.
// Backpressure: req_ready is registered from FIFO occupancy; responses are pulses that cannot stall.
module apb_req_master
    import apb_req_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [APB_ADDR_W-1:0] req_addr,
    input  logic [APB_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [APB_ADDR_W-1:0] paddr,
    output logic [APB_DATA_W-1:0] pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic                  pready,
    input  logic [APB_DATA_W-1:0] prdata
);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("apb_req_master: TIMEOUT_CYC must be in 2..255");
    end

    req_t                  req_dat;
    req_t                  fifo_dat;
    logic                  fifo_vld;
    logic                  fifo_pop;
    logic                  start;
    logic                  tmo_hit;

    apb_state_e            state_q, state_d;
    logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    assign req_dat = '{write: req_write, addr: req_addr, wdata: req_wdata};

    apb_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .pclk    (pclk),
        .preset  (preset),
        .in_vld  (req_valid),
        .in_rdy  (req_ready),
        .in_dat  (req_dat),
        .out_vld (fifo_vld),
        .out_rdy (fifo_pop),
        .out_dat (fifo_dat)
    );

`ifdef APB_REQ_MASTER_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       rsp_err_q, rsp_err_d;

    // Abort on the cycle that would make the stalled-ACCESS count reach TIMEOUT_CYC.
    assign tmo_hit = (state_q == ST_ACCESS) && !pready && (tmo_cnt_q == 8'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        rsp_err_d = tmo_hit;
        if (state_q == ST_SETUP) begin
            tmo_cnt_d = '0;
        end else if (state_q == ST_ACCESS && !pready) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        start       = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start = fifo_vld;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    if (!pwrite_q) begin
                        rsp_rdata_d = prdata;
                    end
                    // Chain straight into the next SETUP so bursts have no idle gap.
                    if (fifo_vld) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start) begin
            state_d  = ST_SETUP;
            fifo_pop = 1'b1;
            paddr_d  = fifo_dat.addr;
            pwdata_d = fifo_dat.wdata;
            pwrite_d = fifo_dat.write;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Decoded from the state flop so reset drops them without waiting for a clock.
    assign psel      = (state_q != ST_IDLE);
    assign penable   = (state_q == ST_ACCESS);
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pwrite    = pwrite_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: directed scenarios plus randomized traffic against a request-level model.
// Timeout scenario only runs when APB_REQ_MASTER_TIMEOUT_EN is defined.
module tb_apb_req_master;

    logic        pclk;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic        pready;
    logic [31:0] prdata;

    apb_req_master #(
        .FIFO_DEPTH  (2),
        .TIMEOUT_CYC (4)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .pready    (pready),
        .prdata    (prdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    int          rsp_times[$];
    logic [31:0] ref_mem [16];
    logic [31:0] smem [16];
    logic [31:0] last_rdata;
    logic [63:0] setup_bus;
    int          wait_cfg = 0;
    bit          rand_waits = 0;
    int          waits_left = 0;
    bit          saw_full = 0;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge pclk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // APB slave: wait states chosen at SETUP, memory updated when a write completes.
    always @(negedge pclk) begin
        if (psel && !penable) begin
            waits_left = rand_waits ? int'($urandom_range(0, 2)) : wait_cfg;
            pready = 1'b0;
            prdata = $urandom;
        end else if (psel && penable) begin
            if (waits_left > 0) begin
                waits_left--;
                pready = 1'b0;
                prdata = $urandom;
            end else begin
                pready = 1'b1;
                if (pwrite) begin
                    smem[paddr[3:0]] = pwdata;
                    prdata = $urandom;
                end else begin
                    prdata = smem[paddr[3:0]];
                end
            end
        end else begin
            pready = 1'b0;
            prdata = $urandom;
        end
    end

    // Response scoreboard and bus-stability monitor.
    always @(negedge pclk) begin
        if (!preset) begin
            if (rsp_valid) begin
                rsp_times.push_back(cyc);
                last_rdata = rsp_rdata;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end
            if (psel && !penable) setup_bus = 64'({pwrite, pwdata, paddr});
            if (psel && penable) check("bus_stable", 64'({pwrite, pwdata, paddr}), setup_bus);
        end
    end

    task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d, input bit abort);
        bit   acc;
        int   n;
        exp_t e;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge pclk);
            acc = req_ready;
            if (!req_ready) saw_full = 1'b1;
            @(posedge pclk);
            #1;
            n++;
        end
        check("send_accept", 64'(acc), 64'(1));
        if (acc) begin
            if (abort) begin
                e.rdata = 32'h0;
                e.err   = 1'b1;
            end else if (w) begin
                ref_mem[a[3:0]] = d;
                e.rdata = 32'h0;
                e.err   = 1'b0;
            end else begin
                e.rdata = ref_mem[a[3:0]];
                e.err   = 1'b0;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge pclk);
            #1;
            n++;
        end
        repeat (2) @(posedge pclk);
        #1;
        check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_idle"}, 64'(psel), 64'(0));
    endtask

    initial begin
        int          base;
        int          acc_cnt;
        int          rsp_cnt;
        int          psel_cnt;
        int          bad;
        bit          got;
        logic [31:0] bd [4];

        preset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        setup_bus = '0;
        last_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            smem[i]    = '0;
        end

        // Reset values
        repeat (3) @(posedge pclk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_psel_penable", 64'({psel, penable}), 64'(0));
        check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
        check("rst_bus", 64'({pwrite, pwdata, paddr}), 64'(0));
        preset = 1'b0;
        #1;
        check("rdy_before_edge", 64'(req_ready), 64'(0));
        @(posedge pclk);
        #1;
        check("rdy_first_edge", 64'(req_ready), 64'(1));

        // Single write: latency and phase sequence
        send(1'b1, 16'h0003, 32'hDEADBEEF, 1'b0);
        req_valid = 1'b0;
        check("lat_n_idle", 64'({psel, penable}), 64'(0));
        @(posedge pclk);
        #1;
        check("lat_setup", 64'({psel, penable}), 64'(2'b10));
        @(posedge pclk);
        #1;
        check("lat_access", 64'({psel, penable, rsp_valid}), 64'(3'b110));
        @(posedge pclk);
        #1;
        check("lat_rsp", 64'({rsp_valid, psel}), 64'(2'b10));
        check("lat_rsp_rdata", 64'(rsp_rdata), 64'(0));
        drain("single_write");

        send(1'b0, 16'h0003, 32'h0, 1'b0);
        req_valid = 1'b0;
        drain("single_read");
        check("read_back", 64'(last_rdata), 64'(32'hDEADBEEF));

        // Burst with req_valid held high
        saw_full = 1'b0;
        base = rsp_times.size();
        for (int i = 0; i < 4; i++) bd[i] = $urandom;
        for (int i = 0; i < 4; i++) send(1'b1, 16'(i), bd[i], 1'b0);
        for (int i = 0; i < 4; i++) send(1'b0, 16'(i), 32'h0, 1'b0);
        req_valid = 1'b0;
        drain("burst");
        check("burst_ready_low", 64'(saw_full), 64'(1));
        check("burst_rsp_count", 64'(rsp_times.size() - base), 64'(8));
        if (rsp_times.size() - base == 8) begin
            for (int i = 1; i < 8; i++)
                check("burst_spacing", 64'(rsp_times[base+i] - rsp_times[base+i-1]), 64'(2));
        end

        // Three wait states on a read
        wait_cfg = 3;
        send(1'b0, 16'h0001, 32'h0, 1'b0);
        req_valid = 1'b0;
        acc_cnt = 0;
        rsp_cnt = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (psel && penable) begin
                acc_cnt++;
                if (paddr !== 16'h0001) bad++;
            end
            if (rsp_valid) rsp_cnt++;
        end
        check("wait_access_cycles", 64'(acc_cnt), 64'(4));
        check("wait_paddr_stable", 64'(bad), 64'(0));
        check("wait_rsp_count", 64'(rsp_cnt), 64'(1));
        wait_cfg = 0;
        drain("wait");

`ifdef APB_REQ_MASTER_TIMEOUT_EN
        // Timeout abort, then the queued request proceeds
        wait_cfg = 1000;
        send(1'b1, 16'h0005, 32'h12345678, 1'b1);
        send(1'b0, 16'h0005, 32'h0, 1'b0);
        req_valid = 1'b0;
        acc_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge pclk);
            if (psel && penable) acc_cnt++;
            if (rsp_valid) begin
                got = 1'b1;
                wait_cfg = 0;
                check("tmo_psel_low", 64'({psel, penable}), 64'(0));
                check("tmo_err", 64'({rsp_err, rsp_rdata}), 64'({1'b1, 32'h0}));
            end
        end
        check("tmo_rsp_seen", 64'(got), 64'(1));
        check("tmo_access_cycles", 64'(acc_cnt), 64'(4));
        wait_cfg = 0;
        drain("timeout");
`endif

        // Reset in the middle of ACCESS with two requests queued
        wait_cfg = 1000;
        send(1'b0, 16'h0002, 32'h0, 1'b0);
        send(1'b0, 16'h0004, 32'h0, 1'b0);
        send(1'b0, 16'h0006, 32'h0, 1'b0);
        req_valid = 1'b0;
        check("mid_access", 64'({psel, penable, req_ready}), 64'(3'b110));
        #2;
        preset = 1'b1;
        #1;
        check("rst_async_psel", 64'({psel, penable}), 64'(0));
        exp_q.delete();
        @(posedge pclk);
        #1;
        check("rst_hold_outputs", 64'({req_ready, rsp_valid}), 64'(0));
        @(posedge pclk);
        #1;
        preset = 1'b0;
        wait_cfg = 0;
        check("rst_rel_rdy_low", 64'(req_ready), 64'(0));
        @(posedge pclk);
        #1;
        check("rst_rel_rdy_high", 64'(req_ready), 64'(1));
        rsp_cnt = 0;
        psel_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (rsp_valid) rsp_cnt++;
            if (psel) psel_cnt++;
        end
        check("rst_no_rsp", 64'(rsp_cnt), 64'(0));
        check("rst_queue_discarded", 64'(psel_cnt), 64'(0));

        // Randomized traffic with random wait states and request gaps
        rand_waits = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            req_valid = 1'b0;
            repeat (gap) begin
                @(posedge pclk);
                #1;
            end
            send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom, 1'b0);
        end
        req_valid = 1'b0;
        drain("random");
        rand_waits = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
